// File: rtl/ym_ram_pkg.sv
// ym_ram_pkg: definitions shared by the sound-RAM readback path.
//   - state_e   : reader FSM states
//   - TAG_MEM   : source tag for bytes loaded from the mem bus during reset
//   - TAG_CPU   : source tag for bytes written by the sound CPU
//   - ROM_BYTES : size of the sound-RAM image (largest possible transfer)
//   - tag_ok()  : true when a word tag is one of the two legal values
package ym_ram_pkg;

    localparam logic [7:0] TAG_MEM   = 8'h55;
    localparam logic [7:0] TAG_CPU   = 8'haa;
    localparam int         ROM_BYTES = 65536;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    function automatic logic tag_ok(input logic [7:0] tag);
        return (tag == TAG_MEM) || (tag == TAG_CPU);
    endfunction

endpackage

// File: rtl/ym_ram_reader_fifo.sv
// ym_ram_reader_fifo: 2-entry FIFO with a registered head.
// The head entry lives in its own register, so the stream data output comes
// straight from a flop and holds steady until it is popped.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write an entry (accepted when not full, or full with pop)
//   pop          : remove the head entry (ignored when empty)
//   head         : current head entry (registered)
//   count        : number of stored entries, 0..2
//   empty, full  : count == 0 / count == 2
module ym_ram_reader_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            if (do_pop) begin
                if (count == 2'd2) begin
                    head <= tail;
                    if (do_push) tail <= din;
                end else if (do_push) begin
                    // single entry replaced in the same cycle
                    head <= din;
                end
            end else if (do_push) begin
                if (count == 2'd0) head <= din;
                else               tail <= din;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ym_ram_reader.sv
// ym_ram_reader: streams a range of the sound-CPU RAM image out of PSRAM.
// One-word reads, at most one outstanding, results buffered in a 2-entry
// FIFO and presented as a valid/ready byte stream with a last marker.
// Optional feature: define YM_RAM_READER_CHECK_EN to check every captured
// word tag against TAG_MEM/TAG_CPU and expose a sticky tag_error flag.
// Ports:
//   clk, reset_n           : PSRAM user clock, asynchronous active-low reset
//   start, start_addr      : begin a transfer at a sound-RAM offset (idle only)
//   byte_count             : bytes to read, 0..65536
//   busy, done             : transfer in progress / one-cycle end pulse
//   rd_address, rd_en      : PSRAM read request (one-cycle pulse)
//   rd_ack, rd_data        : PSRAM read completion and data
//   out_data/valid/ready   : byte stream, out_last marks the final byte
//   tag_error              : sticky bad-tag flag (YM_RAM_READER_CHECK_EN only)
module ym_ram_reader
    import ym_ram_pkg::*;
#(
    parameter int                    ADDRESS_BITS = 23,
    parameter logic [ADDRESS_BITS-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [15:0]             start_addr,
    input  logic [16:0]             byte_count,
    output logic                    busy,
    output logic                    done,
    output logic [ADDRESS_BITS-1:0] rd_address,
    output logic                    rd_en,
    input  logic                    rd_ack,
    input  logic [15:0]             rd_data,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
`ifdef YM_RAM_READER_CHECK_EN
    ,
    output logic                    tag_error
`endif
);

    localparam int CNT_W = $clog2(ROM_BYTES) + 1;

    state_e           state;
    logic [15:0]      a;
    logic [CNT_W-1:0] ri;
    logic [CNT_W-1:0] ro;

    logic             push;
    logic             pop;
    logic [1:0]       fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             accept_start;
    logic             last_pop;

    // A read is outstanding exactly while the FSM sits in WAIT, so in ISSUE
    // the "count + outstanding < 2" room test reduces to the FIFO not full.
    assign rd_en        = (state == ST_ISSUE) && !fifo_full;
    assign rd_address   = rd_en ? (BASE_ADDR + {{(ADDRESS_BITS-16){1'b0}}, a}) : '0;

    // Acks outside WAIT are stale or spurious and never reach the FIFO.
    assign push         = (state == ST_WAIT) && rd_ack;
    assign pop          = out_valid && out_ready;
    assign accept_start = (state == ST_IDLE) && start;

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_FIN);
    assign out_valid    = !fifo_empty;
    assign out_last     = out_valid && (ro == CNT_W'(1));

    // Leaving DRAIN on the final handshake itself puts done in the very next
    // cycle instead of one cycle later.
    assign last_pop     = (ro == '0) || ((ro == CNT_W'(1)) && pop);

    ym_ram_reader_fifo #(.WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (rd_data[7:0]),
        .pop     (pop),
        .head    (out_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            a     <= '0;
            ri    <= '0;
            ro    <= '0;
        end else begin
            if (pop) ro <= ro - CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a     <= start_addr;
                        ri    <= byte_count;
                        ro    <= byte_count;
                        state <= (byte_count == '0) ? ST_FIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rd_en) begin
                        a     <= a + 16'd1;
                        ri    <= ri - CNT_W'(1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rd_ack) state <= (ri != '0) ? ST_ISSUE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (last_pop) state <= ST_FIN;
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef YM_RAM_READER_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          tag_error <= 1'b0;
        else if (accept_start)                 tag_error <= 1'b0;
        else if (push && !tag_ok(rd_data[15:8])) tag_error <= 1'b1;
    end
`else
    logic unused_tag;
    assign unused_tag = ^{rd_data[15:8], accept_start};
`endif

endmodule

// File: tb/tb_ym_ram_reader.sv
module tb_ym_ram_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [16:0] byte_count = '0;
    logic        busy, done, rd_en, out_valid, out_last;
    logic [22:0] rd_address;
    logic        rd_ack = 1'b0;
    logic [15:0] rd_data = '0;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
`ifdef YM_RAM_READER_CHECK_EN
    logic        tag_error;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ym_ram_reader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .byte_count (byte_count),
        .busy       (busy),
        .done       (done),
        .rd_address (rd_address),
        .rd_en      (rd_en),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
`ifdef YM_RAM_READER_CHECK_EN
        ,
        .tag_error  (tag_error)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PSRAM model: captures rd_en, answers two cycles later with rd_ack.
    logic [15:0] mem [0:65535];
    bit          model_en = 1'b1;
    int          inject_seq = 0;
    logic [15:0] inject_data = '0;
    int          clr_seq = 0;

    int          mdl_inject_done = 0;
    int          mdl_clr_done = 0;
    bit          pend = 1'b0;
    int          pcnt = 0;
    logic [15:0] paddr = '0;
    int          first_ack_cyc = -1;

    always @(negedge clk) begin
        if (mdl_clr_done != clr_seq) begin
            mdl_clr_done = clr_seq;
            first_ack_cyc = -1;
        end
        rd_ack = 1'b0;
        if (mdl_inject_done != inject_seq) begin
            mdl_inject_done = inject_seq;
            rd_ack  = 1'b1;
            rd_data = inject_data;
        end else if (pend) begin
            if (pcnt == 0) begin
                rd_ack  = 1'b1;
                rd_data = mem[paddr];
                pend    = 1'b0;
                if (first_ack_cyc < 0) first_ack_cyc = cyc;
            end else begin
                pcnt = pcnt - 1;
            end
        end
        if (model_en && rd_en && !pend) begin
            pend  = 1'b1;
            paddr = rd_address[15:0];
            pcnt  = 1;
        end
    end

    // Stream / request monitor.
    int          mon_clr_done = 0;
    int          n_rden = 0;
    int          n_done = 0;
    int          n_valid = 0;
    int          first_valid_cyc = -1;
    int          last_hs_cyc = -1;
    int          done_cyc = -1;
    logic [22:0] addr_q [$];
    logic [7:0]  byte_q [$];
    logic        last_q [$];

    always @(negedge clk) begin
        if (mon_clr_done != clr_seq) begin
            mon_clr_done = clr_seq;
            n_rden = 0; n_done = 0; n_valid = 0;
            first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
            addr_q.delete(); byte_q.delete(); last_q.delete();
        end
        if (rd_en) begin
            n_rden = n_rden + 1;
            addr_q.push_back(rd_address);
        end
        if (out_valid) begin
            n_valid = n_valid + 1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            byte_q.push_back(out_data);
            last_q.push_back(out_last);
            last_hs_cyc = cyc;
        end
        if (done) begin
            n_done = n_done + 1;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns 1ns into cycle 1.
    task automatic start_xfer(input logic [15:0] sa, input logic [16:0] bc);
        clr_seq    = clr_seq + 1;
        start_addr = sa;
        byte_count = bc;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            if (n_done > 0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: no done pulse within 300 cycles", name);
        end
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp [4], input int n);
        checks++;
        if (byte_q.size() != n) begin
            errors++;
            $display("FAIL %s_byte_count: got %0d expected %0d", name, byte_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (byte_q[i] !== exp[i] || last_q[i] !== (i == n - 1)) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h last=%b expected %h last=%b",
                             name, i, byte_q[i], last_q[i], exp[i], (i == n - 1));
                end
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, rd_en, out_valid, out_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/rd_en/valid/last=%b expected 00000",
                     {busy, done, rd_en, out_valid, out_last});
        end
        checks++;
        if (out_data !== 8'h00 || rd_address !== 23'h0) begin
            errors++;
            $display("FAIL reset_data: got out_data=%h rd_address=%h expected 00 / 0",
                     out_data, rd_address);
        end
`ifdef YM_RAM_READER_CHECK_EN
        checks++;
        if (tag_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_tag_error: got %b expected 0", tag_error);
        end
`endif
    endtask

    task automatic test_basic();
        logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        out_ready = 1'b1;
        start_xfer(16'h0010, 17'd4);
        checks++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || rd_address !== 23'h10) begin
            errors++;
            $display("FAIL basic_cycle1: got busy=%b rd_en=%b addr=%h expected 1 1 000010",
                     busy, rd_en, rd_address);
        end
        wait_done("basic");
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: got busy=%b done=%b expected 0 0", busy, done);
        end
        check_bytes("basic", exp, 4);
        checks++;
        if (n_rden != 4 || n_done != 1) begin
            errors++;
            $display("FAIL basic_counts: got rd_en=%0d done=%0d expected 4 1", n_rden, n_done);
        end
        checks++;
        if (first_valid_cyc != first_ack_cyc + 1) begin
            errors++;
            $display("FAIL basic_ack_latency: got valid cycle %0d expected %0d",
                     first_valid_cyc, first_ack_cyc + 1);
        end
        checks++;
        if (done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL basic_done_timing: got done cycle %0d expected %0d",
                     done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_wrap();
        start_xfer(16'hfffe, 17'd3);
        wait_done("wrap");
        checks++;
        if (addr_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_rd_count: got %0d expected 3", addr_q.size());
        end else begin
            checks++;
            if (addr_q[0] !== 23'h00fffe || addr_q[1] !== 23'h00ffff || addr_q[2] !== 23'h000000) begin
                errors++;
                $display("FAIL wrap_addr: got %h %h %h expected 00fffe 00ffff 000000",
                         addr_q[0], addr_q[1], addr_q[2]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        out_ready = 1'b0;
        start_xfer(16'h0010, 17'd4);
        repeat (20) step();
        checks++;
        if (n_rden != 2 || out_valid !== 1'b1 || out_data !== 8'hA1) begin
            errors++;
            $display("FAIL stall_state: got rd_en=%0d valid=%b data=%h expected 2 1 a1",
                     n_rden, out_valid, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_data !== 8'hA1 || n_rden != 2) begin
                errors++;
                $display("FAIL stall_hold%0d: got data=%h rd_en=%0d expected a1 2", i, out_data, n_rden);
            end
        end
        out_ready = 1'b1;
        wait_done("stall");
        check_bytes("stall", exp, 4);
        checks++;
        if (n_rden != 4) begin
            errors++;
            $display("FAIL stall_rd_count: got %0d expected 4", n_rden);
        end
    endtask

    task automatic test_zero();
        start_xfer(16'h0010, 17'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_cycle1: got done=%b busy=%b expected 1 1", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_cycle2: got done=%b busy=%b expected 0 0", done, busy);
        end
        repeat (3) step();
        checks++;
        if (n_rden != 0 || n_valid != 0 || n_done != 1) begin
            errors++;
            $display("FAIL zero_activity: got rd_en=%0d valid=%0d done=%0d expected 0 0 1",
                     n_rden, n_valid, n_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [4] = '{8'hC3, 8'hD4, 8'h00, 8'h00};
        model_en = 1'b0;
        start_xfer(16'h0010, 17'd4);
        step();
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en, out_valid, out_last} !== 5'b0 || out_data !== 8'h00 || rd_address !== 23'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got flags=%b data=%h addr=%h expected 00000 00 0",
                     {busy, done, rd_en, out_valid, out_last}, out_data, rd_address);
        end
        step();
        reset_n = 1'b1;
        step();
        clr_seq     = clr_seq + 1;
        inject_data = 16'h55FF;
        inject_seq  = inject_seq + 1;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || byte_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_late_ack: got valid=%b busy=%b bytes=%0d expected 0 0 0",
                     out_valid, busy, byte_q.size());
        end
        model_en = 1'b1;
        start_xfer(16'h0012, 17'd2);
        wait_done("midreset_restart");
        check_bytes("midreset_restart", exp, 2);
    endtask

`ifdef YM_RAM_READER_CHECK_EN
    task automatic test_tag();
        logic [7:0] exp [4] = '{8'hEE, 8'h00, 8'h00, 8'h00};
        mem[16'h0020] = 16'h5511;
        mem[16'h0021] = 16'hAA22;
        mem[16'h0022] = 16'h12EE;
        start_xfer(16'h0020, 17'd2);
        wait_done("tag_good");
        checks++;
        if (tag_error !== 1'b0) begin
            errors++;
            $display("FAIL tag_good: got tag_error=%b expected 0", tag_error);
        end
        start_xfer(16'h0022, 17'd1);
        wait_done("tag_bad");
        check_bytes("tag_bad", exp, 1);
        checks++;
        if (tag_error !== 1'b1) begin
            errors++;
            $display("FAIL tag_bad: got tag_error=%b expected 1", tag_error);
        end
        start_xfer(16'h0020, 17'd1);
        checks++;
        if (tag_error !== 1'b0) begin
            errors++;
            $display("FAIL tag_clear_on_start: got tag_error=%b expected 0", tag_error);
        end
        wait_done("tag_clear");
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = {8'h55, i[7:0]};
        mem[16'h0010] = 16'h55A1;
        mem[16'h0011] = 16'h55B2;
        mem[16'h0012] = 16'h55C3;
        mem[16'h0013] = 16'h55D4;
        repeat (3) step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_basic();
        step();
        test_wrap();
        step();
        test_stall();
        step();
        test_zero();
        step();
        test_reset_mid();
`ifdef YM_RAM_READER_CHECK_EN
        step();
        test_tag();
`endif
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
